// File: rtl/m_scan_mux.sv
// m_scan_mux: registered N-channel AND-OR mux with auto-scan sequencer.
// Optional freeze input enabled by defining SCANMUX_HOLD_EN.
module m_scan_mux #(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 8,
  parameter  int DWELL_W  = 4,
  localparam int CW       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       gate,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic                      start,
`ifdef SCANMUX_HOLD_EN
  input  logic                      hold,
`endif
  output logic [WIDTH-1:0]          z,
  output logic [CW-1:0]             chan,
  output logic                      strobe,
  output logic                      sweep_done
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  state_t state, state_n;

  logic [WIDTH-1:0]   z_n;
  logic [WIDTH-1:0]   manual;
  logic [WIDTH-1:0]   scan_word;
  logic [CW-1:0]      chan_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic               first, first_n;
  logic               wrap, wrap_n;
  logic               strobe_n;
  logic               sweep_done_n;
  logic               freeze;
  logic               last;

`ifdef SCANMUX_HOLD_EN
  assign freeze = hold;
`else
  assign freeze = 1'b0;
`endif

  assign last = (chan == LAST);

  // AND-OR gate: bitwise OR of every gated channel word
  always_comb begin
    manual = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gate[i]) begin
        manual = manual | din[i*WIDTH +: WIDTH];
      end
    end
  end

  // word of the channel currently being scanned
  always_comb begin
    scan_word = din[int'(chan)*WIDTH +: WIDTH];
  end

  // next-state and next-output logic; freeze keeps all state
  always_comb begin
    state_n      = state;
    z_n          = z;
    chan_n       = chan;
    cnt_n        = cnt;
    first_n      = first;
    wrap_n       = wrap;
    strobe_n     = 1'b0;
    sweep_done_n = 1'b0;
    if (!freeze) begin
      unique case (state)
        IDLE: begin
          chan_n  = '0;
          first_n = 1'b0;
          wrap_n  = 1'b0;
          if (mode) begin
            state_n = SCAN;
            cnt_n   = dwell;
            first_n = 1'b1;
          end else begin
            z_n = manual;
          end
        end
        SCAN: begin
          if (!mode) begin
            state_n = IDLE;
            chan_n  = '0;
            first_n = 1'b0;
            wrap_n  = 1'b0;
            z_n     = manual;
          end else begin
            z_n          = scan_word;
            strobe_n     = first;
            sweep_done_n = first & wrap;
            first_n      = 1'b0;
            wrap_n       = 1'b0;
            if (start) begin
              chan_n  = '0;
              cnt_n   = dwell;
              first_n = 1'b1;
            end else if (cnt == '0) begin
              chan_n  = last ? '0 : chan + 1'b1;
              cnt_n   = dwell;
              first_n = 1'b1;
              wrap_n  = last;
            end else begin
              cnt_n = cnt - 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      z          <= '0;
      chan       <= '0;
      cnt        <= '0;
      first      <= 1'b0;
      wrap       <= 1'b0;
      strobe     <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_n;
      z          <= z_n;
      chan       <= chan_n;
      cnt        <= cnt_n;
      first      <= first_n;
      wrap       <= wrap_n;
      strobe     <= strobe_n;
      sweep_done <= sweep_done_n;
    end
  end

endmodule

// File: tb/tb_m_scan_mux.sv
// tb_m_scan_mux: directed plus randomized checks of m_scan_mux
// against a cycle-level behavioural model.
module tb_m_scan_mux;
  localparam int C = 4;
  localparam int W = 8;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           mode;
  logic           start;
  logic [C-1:0]   gate;
  logic [C*W-1:0] din;
  logic [D-1:0]   dwell;
  logic [W-1:0]   z;
  logic [1:0]     chan;
  logic           strobe;
  logic           sweep_done;
`ifdef SCANMUX_HOLD_EN
  logic           hold = 1'b0;
`endif

  int ntests = 0;
  int nfail  = 0;

  // behavioural model state
  bit         m_scan = 0;
  int         m_ch   = 0;
  int         m_rem  = 0;
  bit         m_new  = 0;
  bit         m_wrap = 0;
  logic [7:0] m_z    = 0;
  bit         m_st   = 0;
  bit         m_sd   = 0;

  always #5 clk = ~clk;

  m_scan_mux #(.CHANNELS(C), .WIDTH(W), .DWELL_W(D)) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .gate(gate),
    .din(din),
    .dwell(dwell),
    .start(start),
`ifdef SCANMUX_HOLD_EN
    .hold(hold),
`endif
    .z(z),
    .chan(chan),
    .strobe(strobe),
    .sweep_done(sweep_done)
  );

  function automatic logic [7:0] word(int i);
    logic [31:0] d;
    d = din;
    return d[i*8 +: 8];
  endfunction

  function automatic logic [7:0] manual_or();
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < C; i++)
      if (gate[i]) r = r | word(i);
    return r;
  endfunction

  // one clock edge of the reference behaviour
  task automatic model_edge();
    bit frz;
    frz = 1'b0;
`ifdef SCANMUX_HOLD_EN
    frz = hold;
`endif
    if (reset) begin
      m_scan = 0; m_ch = 0; m_rem = 0; m_new = 0;
      m_wrap = 0; m_z = 0; m_st = 0; m_sd = 0;
    end else if (frz) begin
      m_st = 0; m_sd = 0;
    end else if (!m_scan || !mode) begin
      m_st = 0; m_sd = 0; m_ch = 0; m_wrap = 0; m_new = 0;
      if (!m_scan && mode) begin
        m_scan = 1; m_rem = dwell; m_new = 1;
      end else begin
        m_scan = 0; m_z = manual_or();
      end
    end else begin
      m_z    = word(m_ch);
      m_st   = m_new;
      m_sd   = m_new && m_wrap;
      m_new  = 0;
      m_wrap = 0;
      if (start) begin
        m_ch = 0; m_rem = dwell; m_new = 1;
      end else if (m_rem == 0) begin
        m_wrap = (m_ch == C - 1);
        m_ch   = (m_ch + 1) % C;
        m_rem  = dwell;
        m_new  = 1;
      end else begin
        m_rem = m_rem - 1;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("z", 32'(z), 32'(m_z));
    chk("chan", 32'(chan), 32'(m_ch));
    chk("strobe", 32'(strobe), 32'(m_st));
    chk("sweep_done", 32'(sweep_done), 32'(m_sd));
  endtask

  logic [7:0] tp_z [9] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33,
                           8'h33, 8'h44, 8'h44, 8'h11};

  initial begin
    reset = 1; mode = 0; start = 0; gate = '0;
    din = 32'h44332211; dwell = 4'd1;
    tick();
    tick();
    chk("rst_z", 32'(z), 32'h0);
    chk("rst_strobe", 32'(strobe), 32'h0);
    reset = 0;
    gate = 4'b0010; tick(); chk("man_1", 32'(z), 32'h22);
    gate = 4'b0101; tick(); chk("man_or", 32'(z), 32'h33);
    gate = 4'b0000; tick(); chk("man_none", 32'(z), 32'h00);

    mode = 1; dwell = 4'd1;
    tick();
    chk("entry_strobe", 32'(strobe), 32'h0);
    chk("entry_z", 32'(z), 32'h00);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("d1_z", 32'(z), 32'(tp_z[k]));
      chk("d1_strobe", 32'(strobe), 32'(k % 2 == 0));
      chk("d1_sweep", 32'(sweep_done), 32'(k == 8));
    end

    mode = 0; tick();
    mode = 1; dwell = 4'd0; tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("d0_strobe", 32'(strobe), 32'h1);
      chk("d0_chan", 32'(chan), 32'((k + 1) % 4));
      chk("d0_sweep", 32'(sweep_done), 32'(k % 4 == 0 && k > 0));
    end

    mode = 0; tick();
    dwell = 4'd1; mode = 1; tick();
    repeat (4) tick();
    chk("pre_start_chan", 32'(chan), 32'h2);
    start = 1; tick(); chk("start_chan", 32'(chan), 32'h0);
    start = 0; tick();
    chk("start_z", 32'(z), 32'h11);
    chk("start_strobe", 32'(strobe), 32'h1);
    chk("start_sweep", 32'(sweep_done), 32'h0);
    dwell = 4'd3; tick(); chk("dw_chan", 32'(chan), 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("dw_z", 32'(z), 32'h22);
    end
    chk("dw_next", 32'(chan), 32'h2);

    reset = 1; tick();
    chk("mid_rst_z", 32'(z), 32'h0);
    chk("mid_rst_chan", 32'(chan), 32'h0);
    reset = 0; tick(); chk("reentry_z", 32'(z), 32'h0);
    tick(); chk("reentry_din0", 32'(z), 32'h11);

    dwell = 4'd0; repeat (2) tick();
    mode = 0; gate = 4'b1000; tick();
    chk("drop_chan", 32'(chan), 32'h0);
    chk("drop_z", 32'(z), 32'h44);

`ifdef SCANMUX_HOLD_EN
    dwell = 4'd3; mode = 1; tick();
    repeat (5) tick();
    chk("h_pre_chan", 32'(chan), 32'h1);
    hold = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("h_strobe", 32'(strobe), 32'h0);
      chk("h_chan", 32'(chan), 32'h1);
      chk("h_z", 32'(z), 32'h22);
    end
    hold = 0;
    repeat (2) tick();
    chk("h_rest_chan", 32'(chan), 32'h1);
    tick();
    chk("h_next_chan", 32'(chan), 32'h2);
`endif

    for (int n = 0; n < 500; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      mode  = ($urandom_range(0, 24) != 0);
      start = ($urandom_range(0, 15) == 0);
      dwell = 4'($urandom_range(0, 3));
      gate  = 4'($urandom);
      din   = $urandom;
`ifdef SCANMUX_HOLD_EN
      hold  = ($urandom_range(0, 9) == 0);
`endif
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
